// File: rtl/wm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wm_pkg
// Description : Shared types and constants for the watermark scan sequencer.
//               Holds the FSM state encoding, the pixel-index width (wide
//               enough for M*M with M up to 1023) and the memory read latency.
// Revision    : 1.0 - initial release
// ============================================================================
package wm_pkg;

    // Image-side width and the matching pixel-index width (M*M fits in 2*side)
    localparam int c_WM_SIZE_W  = 10;
    localparam int c_WM_IDX_W   = 2 * c_WM_SIZE_W;

    // Pixel memories return data one cycle after the read strobe
    localparam int c_WM_RD_LAT  = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } wm_state_t;

endpackage : wm_pkg
`default_nettype wire

// File: rtl/wm_rc_counter.sv
`default_nettype none
// ============================================================================
// Module      : wm_rc_counter
// Description : Raster-order row/column/linear-index counter. Each enabled
//               cycle advances the column; at the last column it wraps to 0
//               and the row increments. The linear index simply increments,
//               so no per-pixel multiply is needed downstream.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               i_clr         - synchronous clear of all counters
//               i_en          - advance by one pixel
//               i_last_col    - M-1, column value at which the row wraps
//               o_row, o_col  - coordinates of the current pixel
//               o_idx         - linear index of the current pixel
// Revision    : 1.0 - initial release
// ============================================================================
module wm_rc_counter
    import wm_pkg::*;
#(
    parameter int SIZE_W = c_WM_SIZE_W,
    parameter int IDX_W  = c_WM_IDX_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    input  logic              i_en,
    input  logic [SIZE_W-1:0] i_last_col,
    output logic [SIZE_W-1:0] o_row,
    output logic [SIZE_W-1:0] o_col,
    output logic [IDX_W-1:0]  o_idx
);

    logic [SIZE_W-1:0] r_row;
    logic [SIZE_W-1:0] r_col;
    logic [IDX_W-1:0]  r_idx;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_row <= '0;
            r_col <= '0;
            r_idx <= '0;
        end else if (i_en) begin
            r_idx <= r_idx + IDX_W'(1);
            if (r_col == i_last_col) begin
                r_col <= '0;
                r_row <= r_row + SIZE_W'(1);
            end else begin
                r_col <= r_col + SIZE_W'(1);
            end
        end
    end

    assign o_row = r_row;
    assign o_col = r_col;
    assign o_idx = r_idx;

endmodule : wm_rc_counter
`default_nettype wire

// File: rtl/wm_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : wm_scan_ctrl
// Description : Scan sequencer for the watermarking datapath. On start it
//               walks an MxM image in raster order issuing one read per pixel
//               to the host and watermark memories, forwards the returned
//               pixel coordinates to the datapath, counts result beats and
//               signals end of image.
// Ports       : clk, rst                 - clock, synchronous active-high reset
//               start, img_size          - command pulse and image side M
//               host_base, wm_base       - image base addresses
//               rd_en, host_addr, wm_addr- memory read strobe and addresses
//               row, col, dp_in_valid    - pixel presented to the datapath
//               dp_ready                 - datapath backpressure
//               dp_out_valid/dp_out_data - datapath result beats
//               new_pixel, Pixel_Data    - registered result strobe and pixel
//               Image_Done               - one-cycle end-of-image pulse
//               busy, size_err           - status and M=0 reject pulse
// Revision    : 1.0 - initial release
// ============================================================================
module wm_scan_ctrl
    import wm_pkg::*;
#(
    parameter int AMBA_ADDR_DEPTH = 20,
    parameter int DATA_DEPTH      = 8,
    parameter int SIZE_WIDTH      = c_WM_SIZE_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [SIZE_WIDTH-1:0]      img_size,
    input  logic [AMBA_ADDR_DEPTH-1:0] host_base,
    input  logic [AMBA_ADDR_DEPTH-1:0] wm_base,
    output logic                       rd_en,
    output logic [AMBA_ADDR_DEPTH-1:0] host_addr,
    output logic [AMBA_ADDR_DEPTH-1:0] wm_addr,
    output logic [SIZE_WIDTH-1:0]      row,
    output logic [SIZE_WIDTH-1:0]      col,
    output logic                       dp_in_valid,
    input  logic                       dp_ready,
    input  logic                       dp_out_valid,
    input  logic [DATA_DEPTH-1:0]      dp_out_data,
    output logic                       new_pixel,
    output logic [DATA_DEPTH-1:0]      Pixel_Data,
    output logic                       Image_Done,
    output logic                       busy,
    output logic                       size_err
);

    localparam int c_IDX_W = 2 * SIZE_WIDTH;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    wm_state_t                  r_state;
    logic [SIZE_WIDTH-1:0]      r_size;
    logic [AMBA_ADDR_DEPTH-1:0] r_host_base;
    logic [AMBA_ADDR_DEPTH-1:0] r_wm_base;
    logic [c_IDX_W-1:0]         r_total;
    logic [c_IDX_W-1:0]         r_out_cnt;
    logic                       r_in_valid;
    logic [SIZE_WIDTH-1:0]      r_row;
    logic [SIZE_WIDTH-1:0]      r_col;
    logic                       r_new_pixel;
    logic [DATA_DEPTH-1:0]      r_pixel_data;
    logic                       r_size_err;

    // ------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------
    wm_state_t                  w_state_nxt;
    logic                       w_rd_en;
    logic                       w_accept;
    logic                       w_reject;
    logic                       w_cnt_clr;
    logic                       w_beat;
    logic [c_IDX_W-1:0]         w_out_cnt_nxt;
    logic [c_IDX_W-1:0]         w_total;
    logic [c_IDX_W-1:0]         w_last_idx;
    logic [SIZE_WIDTH-1:0]      w_cur_row;
    logic [SIZE_WIDTH-1:0]      w_cur_col;
    logic [c_IDX_W-1:0]         w_cur_idx;

    // Single 10x10->20 multiply, only used on the accepting start
    assign w_total    = c_IDX_W'(img_size) * c_IDX_W'(img_size);
    assign w_last_idx = r_total - c_IDX_W'(1);

    // Result beats are only meaningful while a scan is in progress
    assign w_beat        = dp_out_valid && (r_state != ST_IDLE);
    assign w_out_cnt_nxt = r_out_cnt + c_IDX_W'(w_beat);

    // ------------------------------------------------------------------
    // Read-side raster counter
    // ------------------------------------------------------------------
    wm_rc_counter #(
        .SIZE_W (SIZE_WIDTH),
        .IDX_W  (c_IDX_W)
    ) u_rd_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (w_cnt_clr || w_accept),
        .i_en       (w_rd_en),
        .i_last_col (r_size - SIZE_WIDTH'(1)),
        .o_row      (w_cur_row),
        .o_col      (w_cur_col),
        .o_idx      (w_cur_idx)
    );

    // ------------------------------------------------------------------
    // FSM: next state and control
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_rd_en     = 1'b0;
        w_accept    = 1'b0;
        w_reject    = 1'b0;
        w_cnt_clr   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (img_size != '0) begin
                        w_accept    = 1'b1;
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_reject    = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                w_rd_en = dp_ready;
                if (dp_ready && (w_cur_idx == w_last_idx)) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Look at the count including this cycle's beat so DONE lands
                // on the same edge that registers the final new_pixel.
                if (w_out_cnt_nxt == r_total) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_cnt_clr   = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Configuration, counters and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_size       <= '0;
            r_host_base  <= '0;
            r_wm_base    <= '0;
            r_total      <= '0;
            r_out_cnt    <= '0;
            r_in_valid   <= 1'b0;
            r_row        <= '0;
            r_col        <= '0;
            r_new_pixel  <= 1'b0;
            r_pixel_data <= '0;
            r_size_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_size      <= img_size;
                r_host_base <= host_base;
                r_wm_base   <= wm_base;
                r_total     <= w_total;
            end

            if (w_cnt_clr) begin
                r_out_cnt <= '0;
            end else begin
                r_out_cnt <= w_out_cnt_nxt;
            end

            // Memory data for a read is valid one cycle later; the pixel's
            // coordinates travel alongside it.
            r_in_valid <= w_rd_en;
            if (w_rd_en) begin
                r_row <= w_cur_row;
                r_col <= w_cur_col;
            end

            r_new_pixel <= w_beat;
            if (w_beat) begin
                r_pixel_data <= dp_out_data;
            end

            r_size_err <= w_reject;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rd_en       = w_rd_en;
    assign host_addr   = r_host_base + AMBA_ADDR_DEPTH'(w_cur_idx);
    assign wm_addr     = r_wm_base   + AMBA_ADDR_DEPTH'(w_cur_idx);
    assign row         = r_row;
    assign col         = r_col;
    assign dp_in_valid = r_in_valid;
    assign new_pixel   = r_new_pixel;
    assign Pixel_Data  = r_pixel_data;
    assign Image_Done  = (r_state == ST_DONE);
    assign busy        = (r_state != ST_IDLE);
    assign size_err    = r_size_err;

endmodule : wm_scan_ctrl
`default_nettype wire

// File: tb/tb_wm_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_wm_scan_ctrl
// Description : Directed self-checking bench for wm_scan_ctrl. A 3-cycle
//               datapath model returns one beat per dp_in_valid; a negedge
//               monitor checks addresses, coordinates and result pixels.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wm_scan_ctrl;

    localparam int AW = 20;
    localparam int DW = 8;
    localparam int SW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [SW-1:0] img_size;
    logic [AW-1:0] host_base;
    logic [AW-1:0] wm_base;
    logic          rd_en;
    logic [AW-1:0] host_addr;
    logic [AW-1:0] wm_addr;
    logic [SW-1:0] row;
    logic [SW-1:0] col;
    logic          dp_in_valid;
    logic          dp_ready;
    logic          dp_out_valid;
    logic [DW-1:0] dp_out_data;
    logic          new_pixel;
    logic [DW-1:0] Pixel_Data;
    logic          Image_Done;
    logic          busy;
    logic          size_err;

    wm_scan_ctrl #(
        .AMBA_ADDR_DEPTH (AW),
        .DATA_DEPTH      (DW),
        .SIZE_WIDTH      (SW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .img_size     (img_size),
        .host_base    (host_base),
        .wm_base      (wm_base),
        .rd_en        (rd_en),
        .host_addr    (host_addr),
        .wm_addr      (wm_addr),
        .row          (row),
        .col          (col),
        .dp_in_valid  (dp_in_valid),
        .dp_ready     (dp_ready),
        .dp_out_valid (dp_out_valid),
        .dp_out_data  (dp_out_data),
        .new_pixel    (new_pixel),
        .Pixel_Data   (Pixel_Data),
        .Image_Done   (Image_Done),
        .busy         (busy),
        .size_err     (size_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Datapath model: fixed 3-cycle latency, data from a free-running count
    // ------------------------------------------------------------------
    logic [2:0] r_v;
    logic       inj;
    int         cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) r_v <= 3'b000;
        else     r_v <= {r_v[1:0], dp_in_valid};
    end

    assign dp_out_valid = r_v[2] | inj;
    assign dp_out_data  = 8'(cyc * 7) ^ 8'h5A;

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    int            rd_cnt, iv_cnt, np_cnt, done_cnt, err_cnt;
    int            exp_m, exp_total;
    logic [AW-1:0] exp_hb, exp_wb, ea;
    logic [DW-1:0] ed;

    always @(negedge clk) begin
        if (rd_en) begin
            chk("rd_while_not_ready", 32'(dp_ready), 32'd1);
            ea = exp_hb + AW'(rd_cnt);
            chk("host_addr", 32'(host_addr), 32'(ea));
            ea = exp_wb + AW'(rd_cnt);
            chk("wm_addr", 32'(wm_addr), 32'(ea));
            rd_cnt++;
        end
        if (dp_in_valid) begin
            chk("row", 32'(row), iv_cnt / exp_m);
            chk("col", 32'(col), iv_cnt % exp_m);
            iv_cnt++;
        end
        if (new_pixel) begin
            ed = 8'((cyc - 1) * 7) ^ 8'h5A;
            chk("pixel_data", 32'(Pixel_Data), 32'(ed));
            np_cnt++;
        end
        if (Image_Done) begin
            chk("done_with_last_pixel", 32'(new_pixel), 32'd1);
            chk("done_pixel_count", np_cnt, exp_total);
            done_cnt++;
        end
        if (size_err) err_cnt++;
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clr_mon;
        rd_cnt = 0; iv_cnt = 0; np_cnt = 0; done_cnt = 0; err_cnt = 0;
    endtask

    task automatic start_run(input int m, input logic [AW-1:0] hb, input logic [AW-1:0] wb);
        clr_mon();
        exp_m     = m;
        exp_total = m * m;
        exp_hb    = hb;
        exp_wb    = wb;
        img_size  = SW'(m);
        host_base = hb;
        wm_base   = wb;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit toggle);
        int d0;
        bit hit;
        d0  = done_cnt;
        hit = 1'b0;
        for (int c = 0; c < budget && !hit; c++) begin
            tick();
            if (toggle) dp_ready = ((c / 2) % 2) != 0;
            if (done_cnt != d0) hit = 1'b1;
        end
        dp_ready = 1'b1;
        if (!hit) chk("timeout_image_done", done_cnt, d0 + 1);
        chk("busy_low_after_done", 32'(busy), 32'd0);
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        rst = 1'b1; start = 1'b0; img_size = '0; host_base = '0; wm_base = '0;
        dp_ready = 1'b1; inj = 1'b0;
        exp_m = 1; exp_total = 0; exp_hb = '0; exp_wb = '0;
        clr_mon();
        repeat (3) tick();

        // Reset values
        chk("rst_rd_en",      32'(rd_en),       32'd0);
        chk("rst_dp_in_valid",32'(dp_in_valid), 32'd0);
        chk("rst_new_pixel",  32'(new_pixel),   32'd0);
        chk("rst_image_done", 32'(Image_Done),  32'd0);
        chk("rst_busy",       32'(busy),        32'd0);
        chk("rst_size_err",   32'(size_err),    32'd0);
        chk("rst_host_addr",  32'(host_addr),   32'd0);
        chk("rst_wm_addr",    32'(wm_addr),     32'd0);
        chk("rst_row",        32'(row),         32'd0);
        chk("rst_col",        32'(col),         32'd0);
        chk("rst_pixel_data", 32'(Pixel_Data),  32'd0);
        rst = 1'b0;
        tick();

        // M=4, steady ready: first-read timing then full image
        start_run(4, 20'h00100, 20'h00200);
        chk("t1_busy_t1",     32'(busy),        32'd1);
        chk("t1_rd_en_t1",    32'(rd_en),       32'd1);
        chk("t1_in_valid_t1", 32'(dp_in_valid), 32'd0);
        chk("t1_host_addr0",  32'(host_addr),   32'h00100);
        tick();
        chk("t1_in_valid_t2", 32'(dp_in_valid), 32'd1);
        wait_done(100, 1'b0);
        chk("t1_reads",      rd_cnt,   16);
        chk("t1_in_valids",  iv_cnt,   16);
        chk("t1_new_pixels", np_cnt,   16);
        chk("t1_done_count", done_cnt, 1);

        // M=4 with dp_ready toggling every 2 cycles
        start_run(4, 20'h00100, 20'h00200);
        wait_done(200, 1'b1);
        chk("t2_reads",      rd_cnt,   16);
        chk("t2_in_valids",  iv_cnt,   16);
        chk("t2_new_pixels", np_cnt,   16);
        chk("t2_done_count", done_cnt, 1);

        // M=0 rejected
        clr_mon();
        img_size = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t3_size_err",  32'(size_err), 32'd1);
        chk("t3_busy",      32'(busy),     32'd0);
        chk("t3_rd_en",     32'(rd_en),    32'd0);
        tick();
        chk("t3_size_err_pulse", 32'(size_err), 32'd0);
        chk("t3_err_count",      err_cnt,       1);
        chk("t3_no_reads",       rd_cnt,        0);

        // Result beat in IDLE is ignored
        inj = 1'b1;
        tick();
        inj = 1'b0;
        repeat (2) tick();
        chk("t3_idle_beat_ignored", np_cnt, 0);

        // M=1
        start_run(1, 20'h00005, 20'h00007);
        wait_done(50, 1'b0);
        chk("t3_m1_reads",      rd_cnt,   1);
        chk("t3_m1_new_pixels", np_cnt,   1);
        chk("t3_m1_done_count", done_cnt, 1);

        // Start while busy is ignored
        start_run(8, 20'h00300, 20'h00400);
        repeat (4) tick();
        img_size  = SW'(2);
        host_base = 20'h00999;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(300, 1'b0);
        chk("t4_reads",      rd_cnt,   64);
        chk("t4_new_pixels", np_cnt,   64);
        chk("t4_done_count", done_cnt, 1);

        // Reset mid-run
        start_run(8, 20'h01000, 20'h02000);
        for (int c = 0; c < 100 && rd_cnt < 20; c++) tick();
        chk("t5_reached_20_reads", 32'(rd_cnt >= 20), 32'd1);
        rst = 1'b1;
        tick();
        chk("t5_rd_en",       32'(rd_en),       32'd0);
        chk("t5_in_valid",    32'(dp_in_valid), 32'd0);
        chk("t5_new_pixel",   32'(new_pixel),   32'd0);
        chk("t5_image_done",  32'(Image_Done),  32'd0);
        chk("t5_busy",        32'(busy),        32'd0);
        chk("t5_host_addr",   32'(host_addr),   32'd0);
        chk("t5_row",         32'(row),         32'd0);
        chk("t5_col",         32'(col),         32'd0);
        chk("t5_pixel_data",  32'(Pixel_Data),  32'd0);
        rst = 1'b0;
        repeat (6) tick();
        chk("t5_no_done", done_cnt, 0);
        start_run(2, 20'h00010, 20'h00020);
        wait_done(50, 1'b0);
        chk("t5_m2_new_pixels", np_cnt,   4);
        chk("t5_m2_done_count", done_cnt, 1);

        // Address wrap at the top of the address space
        start_run(1023, 20'hFFFFF, 20'h00010);
        chk("t6_host_addr0", 32'(host_addr), 32'hFFFFF);
        tick();
        chk("t6_host_addr1", 32'(host_addr), 32'h00000);
        chk("t6_wm_addr1",   32'(wm_addr),   32'h00011);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("t6_busy_after_rst", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_wm_scan_ctrl
`default_nettype wire

// File: doc/wm_scan_ctrl.md
# wm_scan_ctrl

Sequencer for the watermarking datapath. On a start command it walks an M×M image in raster order and issues one read per pixel to the host and watermark pixel memories. It hands each returned pixel pair to the datapath, then counts the datapath's result beats. It produces the `new_pixel` strobe, `Pixel_Data` and the `Image_Done` pulse that the verification interface (and the gold-model checker on it) consumes.

## Interface
- Amba_Addr_Depth, 20, pixel memory address width
- Data_Depth, 8, pixel width
- Size_Width, 10, image-side width; M ranges 1..1023

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle command pulse
- img_size  in  Size_Width  M, sampled on accepted start
- host_base  in  Amba_Addr_Depth  host image base address, sampled on start
- wm_base  in  Amba_Addr_Depth  watermark image base address, sampled on start
- rd_en  out  1  read strobe to both pixel memories
- host_addr, wm_addr  out  Amba_Addr_Depth  read addresses, valid with rd_en
- row, col  out  Size_Width  coordinates of the pixel presented with dp_in_valid
- dp_in_valid  out  1  memory data (1-cycle read latency) valid for the datapath
- dp_ready  in  1  datapath can accept; must absorb one beat after deasserting
- dp_out_valid  in  1  datapath result beat
- dp_out_data  in  Data_Depth  result pixel
- new_pixel  out  1  registered result strobe
- Pixel_Data  out  Data_Depth  registered result pixel
- Image_Done  out  1  one-cycle end-of-image pulse
- busy  out  1  high in every state except IDLE
- size_err  out  1  one-cycle pulse when start is rejected for M=0

## Operation
- State machine: IDLE → RUN → DRAIN → DONE → IDLE.
- **IDLE**
  - start with M≠0: latch M, both bases and total=M·M (one 10×10→20 multiply, registered); go to RUN.
  - start with M=0: pulse size_err, stay in IDLE.
- **RUN**
  - rd_en = dp_ready.
  - Each issued read advances col. When col reaches M-1, col wraps to 0 and row increments.
  - host_addr = host_base + idx and wm_addr = wm_base + idx, where idx is an incremental pixel index (no per-pixel multiply). Sums wrap modulo 2^Amba_Addr_Depth.
  - After the read with idx = total-1 is issued, go to DRAIN.
- **DRAIN**
  - No reads.
  - Wait until out_cnt (count of dp_out_valid beats) equals total, then go to DONE.
- **DONE**
  - Image_Done = 1 for this single cycle.
  - Clear counters, go to IDLE.
- dp_in_valid, row and col are rd_en and its coordinates delayed one cycle.
- new_pixel and Pixel_Data are dp_out_valid and dp_out_data registered one cycle.
- dp_out_valid beats arriving in IDLE are ignored (not counted, no new_pixel).
- start while busy is ignored; the latched configuration is unchanged.
- Reset mid-operation: all state is discarded and the FSM returns to IDLE. Image_Done is not pulsed.

## Timing
- Reset values: rd_en, dp_in_valid, new_pixel, Image_Done, busy, size_err = 0; addresses, row, col, Pixel_Data = 0.
- start sampled at edge t:
  - RUN and busy from t+1.
  - First rd_en at t+1 (if dp_ready); first dp_in_valid at t+2.
- Throughput: one pixel per cycle while dp_ready is high.
- The last dp_out_valid at edge u gives:
  - the final new_pixel at u+1;
  - DONE at u+1, so Image_Done at u+1, coincident with the final new_pixel;
  - IDLE, busy low, at u+2.
- A new start is accepted from u+2.
- M=1: total=1; RUN lasts one issuing cycle.

## Structure
- Package wm_pkg holds:
  - the state enum (IDLE, RUN, DRAIN, DONE);
  - the WM_IDX_W = 2·Size_Width constant;
  - the memory read-latency constant (1).
- Sub-module wm_rc_counter: row/col/idx counter with enable, clear and wrap at M-1; instanced once for the read side.
- Out_cnt is a plain counter in the top level.
- Target size: 150–250 lines.

## Test plan
- M=4, host_base=0x00100, wm_base=0x00200, dp_ready=1, datapath delay 3:
  - 16 reads at consecutive addresses 0x00100..0x0010F and 0x00200..0x0020F;
  - row/col sequence (0,0)…(3,3);
  - 16 new_pixel strobes;
  - Image_Done one pulse, coincident with the last new_pixel.
- M=4 with dp_ready toggling every 2 cycles:
  - no read issued while dp_ready=0;
  - exactly 16 dp_in_valid and 16 new_pixel strobes;
  - address order preserved.
- img_size=0 start → size_err pulse; busy stays 0; no rd_en. Then M=1 start → one read and one Image_Done.
- Second start 5 cycles into an M=8 run with img_size=2 → ignored; 64 pixels processed; one Image_Done.
- rst asserted mid-RUN of M=8 (after 20 reads):
  - next cycle all outputs at reset values and no Image_Done;
  - a following M=2 run completes with 4 pixels.
- M=1023, host_base=0xFFFFF → host_addr wraps to 0x00000 on the second read; total=1046529 new_pixel strobes before Image_Done.
